// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  // Frame FSM states: waiting for a start bit, shifting data, parity, stop.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
  localparam int         PS2_FRAME_LEN  = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchroniser, persistence glitch filter and a
// one-cycle strobe on each falling edge of the filtered level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Filtered level only follows the synchronised line once it has disagreed
  // for FILTER_LEN consecutive samples; any agreeing sample restarts the count.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; everything presets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt = filt_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_message_receiver.sv
// PS/2 keyboard receiver: frame FSM, inter-bit timeout and E0/F0 prefix
// folding. Emits one byte per key message with release/extended qualifiers.
module ps2_message_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] message_out,
  output logic       message_latch,
  output logic       release_key,
  output logic       extended_code,
  output logic       frame_error,
  output logic [1:0] dbg_state
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_filt, clk_fall, data_filt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst_n(rst_n), .raw(ps2_clk), .filt(clk_filt), .fall(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst_n(rst_n), .raw(ps2_data), .filt(data_filt), .fall()
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          rel_pend_q, rel_pend_d;
  logic [7:0]    msg_q, msg_d;
  logic          latch_q, latch_d;
  logic          rel_q, rel_d;
  logic          ext_q, ext_d;
  logic          ferr_q, ferr_d;

  // Next-state logic: bit sampling on each filtered clock fall, byte
  // processing at the stop bit, and timeout abort when no fall arrives.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    tmo_d      = '0;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    msg_d      = msg_q;
    latch_d    = 1'b0;
    rel_d      = rel_q;
    ext_d      = ext_q;
    ferr_d     = 1'b0;

    if (clk_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_filt) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
            par_err_d = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          // Data plus parity must hold an odd number of ones.
          par_err_d = ~(^{shift_q, data_filt});
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_filt && !par_err_q) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_REL) begin
              rel_pend_d = 1'b1;
            end else begin
              msg_d      = shift_q;
              ext_d      = ext_pend_q;
              rel_d      = rel_pend_q;
              latch_d    = 1'b1;
              ext_pend_d = 1'b0;
              rel_pend_d = 1'b0;
            end
          end else begin
            ferr_d     = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
        state_d    = ST_IDLE;
        tmo_d      = '0;
        ferr_d     = 1'b1;
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
        shift_d    = '0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      msg_q      <= 8'h00;
      latch_q    <= 1'b0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      msg_q      <= msg_d;
      latch_q    <= latch_d;
      rel_q      <= rel_d;
      ext_q      <= ext_d;
      ferr_q     <= ferr_d;
    end
  end

  assign message_out   = msg_q;
  assign message_latch = latch_q;
  assign release_key   = rel_q;
  assign extended_code = ext_q;
  assign frame_error   = ferr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ps2_message_receiver.sv
// Directed bench for ps2_message_receiver: bit-banged PS/2 frames with
// hand-computed expected bytes, flags and strobe counts.
module tb_ps2_message_receiver;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] message_out;
  logic       message_latch, release_key, extended_code, frame_error;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int latch_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int base_l, base_e;

  ps2_message_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .message_out(message_out), .message_latch(message_latch),
    .release_key(release_key), .extended_code(extended_code),
    .frame_error(frame_error), .dbg_state(dbg_state)
  );

  // clock / strobe monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (message_latch) latch_cnt++;
    if (frame_error) ferr_cnt++;
    if (message_latch && frame_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // frame bits, bit 0 (start) sent first
  function automatic logic [10:0] mk(input logic [7:0] b, input logic pflip, input logic stop);
    return {stop, (~^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic send_raw(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_raw(mk(b, 1'b0, 1'b1), 11);
  endtask

  task automatic snap();
    base_l = latch_cnt;
    base_e = ferr_cnt;
  endtask

  task automatic check_msg(input string tag, input int nl, input int ne,
                           input logic [7:0] m, input logic r, input logic e);
    check({tag, "_latch_cnt"}, latch_cnt - base_l, nl);
    check({tag, "_ferr_cnt"}, ferr_cnt - base_e, ne);
    check({tag, "_msg"}, message_out, m);
    check({tag, "_rel"}, release_key, r);
    check({tag, "_ext"}, extended_code, e);
  endtask

  initial begin
    // reset
    cycles(3);
    check("rst_msg", message_out, 8'h00);
    check("rst_latch", message_latch, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    cycles(20);

    // plain make code
    snap();
    send(8'h1C);
    check_msg("plain_1c", 1, 0, 8'h1C, 1'b0, 1'b0);

    // release prefix: no strobe after F0, flag on the following byte
    snap();
    send(8'hF0);
    check("f0_no_strobe", latch_cnt - base_l, 0);
    send(8'h1C);
    check_msg("rel_1c", 1, 0, 8'h1C, 1'b1, 1'b0);

    // extended release, then plain byte clears flags
    snap();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_msg("ext_rel_75", 1, 0, 8'h75, 1'b1, 1'b1);
    snap();
    send(8'h29);
    check_msg("plain_29", 1, 0, 8'h29, 1'b0, 1'b0);

    // parity error and stop-bit error leave the byte untouched
    snap();
    send_raw(mk(8'h1C, 1'b1, 1'b1), 11);
    check_msg("par_err", 0, 1, 8'h29, 1'b0, 1'b0);
    snap();
    send_raw(mk(8'h1C, 1'b0, 1'b0), 11);
    check_msg("stop_err", 0, 1, 8'h29, 1'b0, 1'b0);

    // timeout after a release prefix and a partial frame
    snap();
    send(8'hF0);
    send_raw(mk(8'h1C, 1'b0, 1'b1), 4);
    check("tmo_state_busy", dbg_state, 2'd1);
    cycles(TIMEOUT_CYCLES + 200);
    check("tmo_ferr_cnt", ferr_cnt - base_e, 1);
    check("tmo_state_idle", dbg_state, 2'd0);
    snap();
    send(8'h29);
    check_msg("after_tmo_29", 1, 0, 8'h29, 1'b0, 1'b0);

    // 3-cycle clock glitch with data low must not start a frame
    snap();
    ps2_data = 1'b0;
    cycles(5);
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(10);
    ps2_data = 1'b1;
    cycles(20);
    check("glitch_state", dbg_state, 2'd0);
    send(8'h1C);
    check_msg("glitch_1c", 1, 0, 8'h1C, 1'b0, 1'b0);

    // reset in the middle of a frame with a release prefix pending
    send(8'hF0);
    send_raw(mk(8'h75, 1'b0, 1'b1), 6);
    rst_n = 1'b0;
    cycles(3);
    check("mid_rst_msg", message_out, 8'h00);
    check("mid_rst_rel", release_key, 1'b0);
    check("mid_rst_ext", extended_code, 1'b0);
    check("mid_rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    cycles(20);
    snap();
    send(8'h1C);
    check_msg("post_rst_1c", 1, 0, 8'h1C, 1'b0, 1'b0);

    check("latch_ferr_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
